// File: rtl/mips_multicycle_controller.sv
// Control FSM for the shared-memory multicycle MIPS datapath.
// Moore outputs per state, gated by mem_ready, zero and opcode legality.
module mips_multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               irwrite,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic [2:0]         alucontrol,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e     state_q, state_d;
    logic [1:0] aluop;
    logic       funct_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcen     = 1'b0;
        aluop    = 2'b00;
        illegal  = 1'b0;

        case (state_q)
            StFetch: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                alusrcb = 2'b11;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    OpRtype: begin
                        if (funct_ok) begin
                            state_d = StExecute;
                        end else begin
                            illegal = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StExecute: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcen    = zero;
                state_d = StFetch;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StJump: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset aborts the current instruction immediately, not at the next edge.
        if (!reset_n) begin
            state_d  = StFetch;
            iord     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            memtoreg = 1'b0;
            regdst   = 1'b0;
            regwrite = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b01;
            pcsrc    = 2'b00;
            pcen     = 1'b0;
            aluop    = 2'b00;
            illegal  = 1'b0;
        end
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            default: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
        endcase
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multicycle MIPS controller; inputs change and outputs
// are sampled just after the falling edge.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        #1;
    endtask

    task automatic next_cycle;
        @(negedge clk);
    endtask

    // lw with two stall cycles in MEMRD
    logic [3:0] lw_st [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       lw_mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        reset_n   = 1'b0;
        op        = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held for three edges
        repeat (3) next_cycle();
        drive(1'b1, 1'b0);
        check("rst_state", state, 4'd0);
        check("rst_pcen", pcen, 1'b0);
        check("rst_irwrite", irwrite, 1'b0);
        check("rst_regwrite", regwrite, 1'b0);
        check("rst_memwrite", memwrite, 1'b0);
        check("rst_alusrcb", alusrcb, 2'b01);

        reset_n = 1'b1;
        op      = 6'b100011;
        drive(1'b1, 1'b0);
        check("fetch_irwrite", irwrite, 1'b1);
        check("fetch_pcen", pcen, 1'b1);
        check("fetch_alusrcb", alusrcb, 2'b01);
        check("fetch_alucontrol", alucontrol, 3'b010);

        for (int i = 0; i < 7; i++) begin
            drive(lw_mr[i], 1'b0);
            check($sformatf("lw_state%0d", i), state, lw_st[i]);
            check($sformatf("lw_regwrite%0d", i), regwrite, lw_st[i] == 4'd4);
            check($sformatf("lw_memtoreg%0d", i), memtoreg, lw_st[i] == 4'd4);
            if (lw_st[i] == 4'd3) check($sformatf("lw_iord%0d", i), iord, 1'b1);
            if (lw_st[i] == 4'd4) check("lw_regdst", regdst, 1'b0);
            next_cycle();
        end

        // R-type slt
        op = 6'b000000; funct = 6'b101010;
        drive(1'b1, 1'b0); check("rt_fetch", state, 4'd0); next_cycle();
        drive(1'b1, 1'b0); check("rt_decode", state, 4'd1);
        check("rt_dec_alusrcb", alusrcb, 2'b11); check("rt_dec_illegal", illegal, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0); check("rt_exec", state, 4'd6);
        check("rt_alucontrol", alucontrol, 3'b111);
        check("rt_alusrca", alusrca, 1'b1); check("rt_alusrcb", alusrcb, 2'b00);
        next_cycle();
        drive(1'b1, 1'b0); check("rt_aluwb", state, 4'd7);
        check("rt_regwrite", regwrite, 1'b1); check("rt_regdst", regdst, 1'b1);
        next_cycle();

        // beq taken then not taken
        op = 6'b000100;
        for (int t = 1; t >= 0; t--) begin
            drive(1'b1, 1'b0); check("beq_fetch", state, 4'd0); next_cycle();
            drive(1'b1, 1'b0); check("beq_decode", state, 4'd1); next_cycle();
            drive(1'b1, t[0]); check("beq_state", state, 4'd8);
            check($sformatf("beq_pcen_z%0d", t), pcen, t[0]);
            check("beq_pcsrc", pcsrc, 2'b01);
            check("beq_alucontrol", alucontrol, 3'b110);
            check("beq_regwrite", regwrite, 1'b0);
            next_cycle();
        end

        // sw with one stall in MEMWR
        op = 6'b101011; funct = 6'b000000;
        drive(1'b1, 1'b0); check("sw_fetch", state, 4'd0); next_cycle();
        drive(1'b1, 1'b0); check("sw_decode", state, 4'd1); next_cycle();
        drive(1'b1, 1'b0); check("sw_memadr", state, 4'd2);
        check("sw_alusrcb", alusrcb, 2'b10); next_cycle();
        drive(1'b0, 1'b0); check("sw_memwr0", state, 4'd5);
        check("sw_memwrite0", memwrite, 1'b1); check("sw_iord0", iord, 1'b1); next_cycle();
        drive(1'b1, 1'b0); check("sw_memwr1", state, 4'd5);
        check("sw_memwrite1", memwrite, 1'b1); check("sw_iord1", iord, 1'b1); next_cycle();
        drive(1'b1, 1'b0); check("sw_done", state, 4'd0); check("sw_memwrite2", memwrite, 1'b0);

        // j
        op = 6'b000010;
        next_cycle();
        drive(1'b1, 1'b0); check("j_decode", state, 4'd1); next_cycle();
        drive(1'b1, 1'b0); check("j_state", state, 4'd11);
        check("j_pcen", pcen, 1'b1); check("j_pcsrc", pcsrc, 2'b10); next_cycle();

        // FETCH stall, then illegal op
        op = 6'b111111;
        drive(1'b0, 1'b0); check("stall_state", state, 4'd0);
        check("stall_irwrite", irwrite, 1'b0); check("stall_pcen", pcen, 1'b0); next_cycle();
        drive(1'b1, 1'b0); check("stall_still_fetch", state, 4'd0); next_cycle();
        drive(1'b1, 1'b0); check("ill_op_decode", state, 4'd1);
        check("ill_op_illegal", illegal, 1'b1);
        check("ill_op_regwrite", regwrite, 1'b0); check("ill_op_memwrite", memwrite, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0); check("ill_op_next", state, 4'd0);
        check("ill_op_pulse", illegal, 1'b0); next_cycle();

        // R-type with unsupported funct
        op = 6'b000000; funct = 6'b000111;
        drive(1'b1, 1'b0); check("ill_fn_decode", state, 4'd1);
        check("ill_fn_illegal", illegal, 1'b1); next_cycle();
        drive(1'b1, 1'b0); check("ill_fn_next", state, 4'd0);
        check("ill_fn_pulse", illegal, 1'b0);
        check("ill_fn_regwrite", regwrite, 1'b0); next_cycle();

        // Reset during MEMWR
        op = 6'b101011;
        drive(1'b1, 1'b0); check("rmw_decode", state, 4'd1); next_cycle();
        drive(1'b1, 1'b0); check("rmw_memadr", state, 4'd2); next_cycle();
        drive(1'b0, 1'b0); check("rmw_memwr", state, 4'd5); check("rmw_memwrite", memwrite, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rmw_memwrite_gated", memwrite, 1'b0);
        check("rmw_iord_fetch", iord, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0); check("rmw_after", state, 4'd0);
        check("rmw_memwrite_after", memwrite, 1'b0);
        reset_n = 1'b1;
        drive(1'b1, 1'b0); check("rmw_release_irwrite", irwrite, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
